// File: rtl/player_lane_ctrl.sv
// Player sprite lane controller: turns left/right key rises into the
// erase / sweep / load / draw command sequence for the player plotter.
module player_lane_ctrl #(
    parameter int BOX_CYCLES = 16,
    parameter int CNT_W      = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       move_left,
    input  logic       move_right,
    output logic       ld_1,
    output logic       ld_2,
    output logic       ld_3,
    output logic       ld_4,
    output logic       erase,
    output logic       draw,
    output logic       plot,
    output logic [1:0] lane,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_INIT_LOAD,
        S_IDLE,
        S_ERASE,
        S_ERASE_SWEEP,
        S_LOAD,
        S_DRAW
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_lane;
    logic [1:0]       r_target;
    logic             r_prev_l;
    logic             r_prev_r;
    logic             r_pend_v;
    logic             r_pend_dir;

    logic       w_rise_l;
    logic       w_rise_r;
    logic       w_req_v;
    logic       w_req_dir;
    logic       w_cand_v;
    logic       w_cand_dir;
    logic       w_cand_ok;
    logic [1:0] w_cand_tgt;
    logic       w_sweep_done;
    logic       w_ld_en;
    logic       w_erase;
    logic       w_draw;
    logic       w_plot;
    logic       w_busy;

    // Direction encoding: 1 = right, 0 = left.
    assign w_rise_l  = move_left & ~r_prev_l;
    assign w_rise_r  = move_right & ~r_prev_r;
    assign w_req_v   = w_rise_l ^ w_rise_r;
    assign w_req_dir = w_rise_r;

    // A fresh rise in IDLE supersedes whatever was queued while busy.
    assign w_cand_v   = w_req_v | r_pend_v;
    assign w_cand_dir = w_req_v ? w_req_dir : r_pend_dir;
    assign w_cand_ok  = w_cand_v &
                        (w_cand_dir ? (r_lane != 2'd3)
                                    : (r_lane != 2'd0));
    assign w_cand_tgt = w_cand_dir ? (r_lane + 2'd1)
                                   : (r_lane - 2'd1);

    assign w_sweep_done = (r_cnt == CNT_W'(BOX_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_INIT_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_INIT_LOAD: begin
                w_next_state = S_DRAW;
            end
            S_IDLE: begin
                if (w_cand_ok) begin
                    w_next_state = S_ERASE;
                end
            end
            S_ERASE: begin
                w_next_state = S_ERASE_SWEEP;
            end
            S_ERASE_SWEEP: begin
                if (w_sweep_done) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next_state = S_DRAW;
            end
            S_DRAW: begin
                if (w_sweep_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_INIT_LOAD;
            end
        endcase
    end

    always_comb begin
        w_ld_en = 1'b0;
        w_erase = 1'b0;
        w_draw  = 1'b0;
        w_plot  = 1'b0;
        w_busy  = 1'b1;
        unique case (r_state)
            S_INIT_LOAD:   w_ld_en = 1'b1;
            S_IDLE:        w_busy  = 1'b0;
            S_ERASE:       w_erase = 1'b1;
            S_ERASE_SWEEP: w_plot  = 1'b1;
            S_LOAD:        w_ld_en = 1'b1;
            S_DRAW: begin
                w_draw = 1'b1;
                w_plot = 1'b1;
            end
            default:       w_busy  = 1'b1;
        endcase
    end

    // Strobes are masked by reset so everything drops the instant it asserts.
    assign ld_1  = reset & w_ld_en & (r_lane == 2'd0);
    assign ld_2  = reset & w_ld_en & (r_lane == 2'd1);
    assign ld_3  = reset & w_ld_en & (r_lane == 2'd2);
    assign ld_4  = reset & w_ld_en & (r_lane == 2'd3);
    assign erase = reset & w_erase;
    assign draw  = reset & w_draw;
    assign plot  = reset & w_plot;
    assign busy  = reset & w_busy;
    assign lane  = r_lane;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_cnt <= '0;
        end else if (r_state == S_ERASE_SWEEP || r_state == S_DRAW) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prev_l <= 1'b0;
            r_prev_r <= 1'b0;
        end else begin
            r_prev_l <= move_left;
            r_prev_r <= move_right;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pend_v   <= 1'b0;
            r_pend_dir <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_pend_v   <= 1'b0;
        end else if (w_req_v) begin
            r_pend_v   <= 1'b1;
            r_pend_dir <= w_req_dir;
        end
    end

    // Lane switches on entry to LOAD so ld_x decodes the new lane.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lane   <= 2'd0;
            r_target <= 2'd0;
        end else begin
            if (r_state == S_IDLE && w_cand_ok) begin
                r_target <= w_cand_tgt;
            end
            if (r_state == S_ERASE_SWEEP && w_sweep_done) begin
                r_lane <= r_target;
            end
        end
    end

endmodule

// File: tb/tb_player_lane_ctrl.sv
// Bench for player_lane_ctrl: directed vector table, hand sequences and
// random key activity checked cycle by cycle against a sequence model.
module tb_player_lane_ctrl;

    localparam int BOX = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       move_left = 1'b0;
    logic       move_right = 1'b0;
    logic       ld_1, ld_2, ld_3, ld_4;
    logic       erase, draw, plot, busy;
    logic [1:0] lane;

    int n_tests = 0;
    int n_fail  = 0;

    player_lane_ctrl #(.BOX_CYCLES(BOX), .CNT_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .move_left  (move_left),
        .move_right (move_right),
        .ld_1       (ld_1),
        .ld_2       (ld_2),
        .ld_3       (ld_3),
        .ld_4       (ld_4),
        .erase      (erase),
        .draw       (draw),
        .plot       (plot),
        .lane       (lane),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // kind: 0 idle, 1 init sequence, 2 move sequence; off = cycles into it
    // pend: 0 none, 1 left, 2 right
    typedef struct {
        int   kind;
        int   off;
        int   lane;
        int   tgt;
        int   pend;
        logic pl;
        logic pr;
    } model_t;

    function automatic model_t model_reset();
        model_t s;
        s.kind = 1;
        s.off  = 0;
        s.lane = 0;
        s.tgt  = 0;
        s.pend = 0;
        s.pl   = 1'b0;
        s.pr   = 1'b0;
        return s;
    endfunction

    function automatic model_t step(model_t s, logic l, logic r);
        model_t n;
        int     req;
        int     cand;
        logic   rl;
        logic   rr;
        n  = s;
        rl = l & ~s.pl;
        rr = r & ~s.pr;
        req = (rl && !rr) ? 1 : ((rr && !rl) ? 2 : 0);
        if (s.kind == 0) begin
            cand   = (req != 0) ? req : s.pend;
            n.pend = 0;
            if (cand == 1 && s.lane > 0) begin
                n.kind = 2;
                n.off  = 0;
                n.tgt  = s.lane - 1;
            end else if (cand == 2 && s.lane < 3) begin
                n.kind = 2;
                n.off  = 0;
                n.tgt  = s.lane + 1;
            end
        end else begin
            if (req != 0) n.pend = req;
            n.off = s.off + 1;
            if (s.kind == 2 && n.off == BOX + 1) n.lane = s.tgt;
            if ((s.kind == 1 && n.off == BOX + 1) ||
                (s.kind == 2 && n.off == 2 * BOX + 2)) begin
                n.kind = 0;
                n.off  = 0;
            end
        end
        n.pl = l;
        n.pr = r;
        return n;
    endfunction

    // {ld_4, ld_3, ld_2, ld_1, erase, draw, plot, lane[1:0], busy}
    function automatic logic [9:0] expv(model_t s);
        logic [3:0] ld;
        logic       e, d, p;
        ld = 4'b0;
        e  = 1'b0;
        d  = 1'b0;
        p  = 1'b0;
        if (s.kind == 1) begin
            if (s.off == 0) ld[s.lane] = 1'b1;
            else begin d = 1'b1; p = 1'b1; end
        end else if (s.kind == 2) begin
            if (s.off == 0) e = 1'b1;
            else if (s.off <= BOX) p = 1'b1;
            else if (s.off == BOX + 1) ld[s.lane] = 1'b1;
            else begin d = 1'b1; p = 1'b1; end
        end
        return {ld, e, d, p, 2'(s.lane), (s.kind != 0)};
    endfunction

    model_t m;
    int     busy_cnt  = 0;
    int     erase_cnt = 0;

    always @(posedge clock or negedge reset) begin
        if (!reset) m <= model_reset();
        else        m <= step(m, move_left, move_right);
    end

    always @(negedge clock) begin
        logic [9:0] dv;
        logic [9:0] ev;
        dv = {ld_4, ld_3, ld_2, ld_1, erase, draw, plot, lane, busy};
        ev = reset ? expv(m) : 10'd0;
        check("cycle_outputs", int'(dv), int'(ev));
        busy_cnt  <= busy_cnt + int'(busy);
        erase_cnt <= erase_cnt + int'(erase);
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    typedef struct {
        logic l;
        logic r;
        int   hold;
        int   wt;
        int   lane;
        int   busy;
        int   erases;
    } vec_t;

    task automatic run_pulses(logic l, logic r, int hold, int wt,
                              output int db, output int de);
        int b0;
        int e0;
        b0 = busy_cnt;
        e0 = erase_cnt;
        move_left  = l;
        move_right = r;
        repeat (hold) tick();
        move_left  = 1'b0;
        move_right = 1'b0;
        repeat (wt) tick();
        db = busy_cnt - b0;
        de = erase_cnt - e0;
    endtask

    vec_t tbl[8];

    initial begin
        int db;
        int de;
        int dcnt;
        int b0;
        int e0;
        m = model_reset();

        tbl[0] = '{1'b1, 1'b0, 1,   40, 0, 0,  0};
        tbl[1] = '{1'b0, 1'b1, 1,   40, 1, 34, 1};
        tbl[2] = '{1'b1, 1'b1, 1,   40, 1, 0,  0};
        tbl[3] = '{1'b0, 1'b1, 200, 40, 2, 34, 1};
        tbl[4] = '{1'b0, 1'b1, 1,   40, 3, 34, 1};
        tbl[5] = '{1'b0, 1'b1, 1,   40, 3, 0,  0};
        tbl[6] = '{1'b1, 1'b0, 1,   40, 2, 34, 1};
        tbl[7] = '{1'b1, 1'b0, 1,   40, 1, 34, 1};

        repeat (3) tick();
        reset = 1'b1;
        @(negedge clock);
        check("init_ld_1", int'(ld_1), 1);
        check("init_busy", int'(busy), 1);
        dcnt = 0;
        repeat (BOX) begin
            @(negedge clock);
            dcnt += int'(draw & plot);
        end
        check("init_draw_cycles", dcnt, BOX);
        @(negedge clock);
        check("init_idle_busy", int'(busy), 0);
        check("init_idle_lane", int'(lane), 0);
        tick();

        for (int i = 0; i < 8; i++) begin
            run_pulses(tbl[i].l, tbl[i].r, tbl[i].hold, tbl[i].wt, db, de);
            check($sformatf("vec%0d_lane", i), int'(lane), tbl[i].lane);
            check($sformatf("vec%0d_busy", i), db, tbl[i].busy);
            check($sformatf("vec%0d_erase", i), de, tbl[i].erases);
        end

        b0 = busy_cnt;
        e0 = erase_cnt;
        run_pulses(1'b0, 1'b1, 1, 5, db, de);
        run_pulses(1'b0, 1'b1, 1, 80, db, de);
        check("queued_lane", int'(lane), 3);
        check("queued_busy", busy_cnt - b0, 2 * (2 * BOX + 2));
        check("queued_erases", erase_cnt - e0, 2);

        move_left = 1'b1;
        tick();
        move_left = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (draw) break;
        end
        check("rst_draw_reached", int'(draw), 1);
        check("rst_target_lane", int'(lane), 2);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("rst_outputs_zero",
              int'({ld_4, ld_3, ld_2, ld_1, erase, draw, plot, busy}), 0);
        check("rst_lane_zero", int'(lane), 0);
        repeat (3) tick();
        reset = 1'b1;
        @(negedge clock);
        check("rst_reinit_ld_1", int'(ld_1), 1);
        repeat (BOX + 4) tick();

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(4) == 0) move_left = ~move_left;
            if ($urandom_range(4) == 0) move_right = ~move_right;
            if ($urandom_range(699) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            tick();
        end
        move_left  = 1'b0;
        move_right = 1'b0;
        repeat (80) tick();
        check("final_idle", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
